pipe_instr_ctrl: RTL

- Owns the instruction pipeline registers D→X→M→W. Drives the stage instructions that the X-stage decoder consumes for control and forwarding.
- Consumes the decoder's flush request and squashes the younger stages.
- Detects load-use hazards, stalls F/D, and inserts bubbles.
- Freezes the whole pipe on a data-memory wait and counts retired instructions.

---
 rtl/pipe_instr_ctrl_if.sv | 44 ++++
 rtl/pipe_instr_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pipe_instr_ctrl_if.sv
// Purpose: bundles the fetch-side inputs and the stage/pipeline-status outputs
//          of the instruction pipeline controller.
// Signals:
//   F_instr, F_valid        fetched instruction and its valid bit
//   flush_F_D               squash request from the X-stage decoder
//   dmem_stall              data memory not ready, freeze the pipe
//   D/X/M/W_instr           stage instructions (NOP in bubbled stages)
//   X/M/W_valid             stage holds a real instruction
//   pc_enable               PC/fetch may advance this cycle (combinational)
//   load_use_stall          load-use hazard stall active (combinational)
//   instret                 retired-instruction counter
// Modports: master = fetch/decoder/memory side, slave = pipeline controller.
interface pipe_instr_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      F_instr;
  logic             F_valid;
  logic             flush_F_D;
  logic             dmem_stall;
  logic [31:0]      D_instr;
  logic [31:0]      X_instr;
  logic [31:0]      M_instr;
  logic [31:0]      W_instr;
  logic             X_valid;
  logic             M_valid;
  logic             W_valid;
  logic             pc_enable;
  logic             load_use_stall;
  logic [CNT_W-1:0] instret;

  modport master (
    output F_instr, F_valid, flush_F_D, dmem_stall,
    input  D_instr, X_instr, M_instr, W_instr,
    input  X_valid, M_valid, W_valid,
    input  pc_enable, load_use_stall, instret
  );

  modport slave (
    input  F_instr, F_valid, flush_F_D, dmem_stall,
    output D_instr, X_instr, M_instr, W_instr,
    output X_valid, M_valid, W_valid,
    output pc_enable, load_use_stall, instret
  );
endinterface

// File: rtl/pipe_instr_ctrl.sv
// Purpose: owns the D->X->M->W instruction registers, inserts bubbles on
//          load-use hazards, squashes D/X on a decoder flush, freezes on a
//          data-memory wait and counts retired instructions.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pipe_instr_ctrl_if.slave (fetch inputs, stage outputs, status)
module pipe_instr_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_instr_ctrl_if.slave bus
);

  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_JAL   = 5'b11011;
  localparam logic [4:0] OPC_OP    = 5'b01100;
  localparam logic [4:0] OPC_STORE = 5'b01000;
  localparam logic [4:0] OPC_BR    = 5'b11000;

  logic [31:0]      d_instr_q, d_instr_d;
  logic [31:0]      x_instr_q, x_instr_d;
  logic [31:0]      m_instr_q, m_instr_d;
  logic [31:0]      w_instr_q, w_instr_d;
  logic             d_valid_q, d_valid_d;
  logic             x_valid_q, x_valid_d;
  logic             m_valid_q, m_valid_d;
  logic             w_valid_q, w_valid_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic             load_use_c;
  logic             pc_enable_c;

  // Load-use hazard between the load in X and its consumer in D.
  always_comb begin
    logic [4:0] d_opc;
    logic [4:0] x_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       x_is_load;
    d_opc     = d_instr_q[6:2];
    x_rd      = x_instr_q[11:7];
    uses_rs1  = !((d_opc == OPC_LUI) || (d_opc == OPC_AUIPC) || (d_opc == OPC_JAL));
    uses_rs2  = (d_opc == OPC_OP) || (d_opc == OPC_STORE) || (d_opc == OPC_BR);
    x_is_load = (x_instr_q[6:2] == OPC_LOAD);
    load_use_c = x_valid_q && x_is_load && (x_rd != 5'd0) && d_valid_q &&
                 ((uses_rs1 && (d_instr_q[19:15] == x_rd)) ||
                  (uses_rs2 && (d_instr_q[24:20] == x_rd)));
  end

  // Fetch may advance unless frozen, or stalled without a redirect.
  assign pc_enable_c = !bus.dmem_stall && (bus.flush_F_D || !load_use_c);

  // Next-state: dmem_stall > flush > load-use stall > normal advance.
  always_comb begin
    d_instr_d = d_instr_q;
    x_instr_d = x_instr_q;
    m_instr_d = m_instr_q;
    w_instr_d = w_instr_q;
    d_valid_d = d_valid_q;
    x_valid_d = x_valid_q;
    m_valid_d = m_valid_q;
    w_valid_d = w_valid_q;
    instret_d = instret_q;

    if (!bus.dmem_stall) begin
      if (w_valid_q) begin
        instret_d = instret_q + CNT_W'(1);
      end
      // M and W always drain when the pipe is not frozen.
      w_instr_d = m_instr_q;
      w_valid_d = m_valid_q;
      m_instr_d = x_instr_q;
      m_valid_d = x_valid_q;

      if (bus.flush_F_D) begin
        x_instr_d = NOP_INSTR;
        x_valid_d = 1'b0;
        d_instr_d = NOP_INSTR;
        d_valid_d = 1'b0;
      end else if (load_use_c) begin
        // D holds; the single bubble lets the load reach M before the consumer reaches X.
        x_instr_d = NOP_INSTR;
        x_valid_d = 1'b0;
      end else begin
        x_instr_d = d_instr_q;
        x_valid_d = d_valid_q;
        d_instr_d = bus.F_valid ? bus.F_instr : NOP_INSTR;
        d_valid_d = bus.F_valid;
      end
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_instr_q <= NOP_INSTR;
      x_instr_q <= NOP_INSTR;
      m_instr_q <= NOP_INSTR;
      w_instr_q <= NOP_INSTR;
      d_valid_q <= 1'b0;
      x_valid_q <= 1'b0;
      m_valid_q <= 1'b0;
      w_valid_q <= 1'b0;
      instret_q <= '0;
    end else begin
      d_instr_q <= d_instr_d;
      x_instr_q <= x_instr_d;
      m_instr_q <= m_instr_d;
      w_instr_q <= w_instr_d;
      d_valid_q <= d_valid_d;
      x_valid_q <= x_valid_d;
      m_valid_q <= m_valid_d;
      w_valid_q <= w_valid_d;
      instret_q <= instret_d;
    end
  end

  assign bus.D_instr        = d_instr_q;
  assign bus.X_instr        = x_instr_q;
  assign bus.M_instr        = m_instr_q;
  assign bus.W_instr        = w_instr_q;
  assign bus.X_valid        = x_valid_q;
  assign bus.M_valid        = m_valid_q;
  assign bus.W_valid        = w_valid_q;
  assign bus.pc_enable      = pc_enable_c;
  assign bus.load_use_stall = load_use_c;
  assign bus.instret        = instret_q;

endmodule
